// File: rtl/pf_ddr4_dqs_tx_seq.sv
// rtl/pf_ddr4_dqs_tx_seq.sv - DDR4 DQS transmit preamble/data/postamble sequencer
//
// Purpose: drives the DQS IOD lane for write bursts with 4:1 gearing (8 UI per
// FAB_CLK cycle). Each accepted request produces a preamble, WR_BURSTS data
// cycles (one BL8 burst per cycle) and a postamble. A request accepted in the
// last data cycle chains seamlessly with no postamble or preamble in between.
//
// Optional feature: define PF_DDR4_DQS_LONG_PREAMBLE_EN for a two-cycle
// preamble (OE 4'b1100 then 4'b1111).
//
// Ports:
//   FAB_CLK    in   1  fabric clock, the only clock
//   ARST       in   1  asynchronous active-high reset
//   WR_REQ     in   1  write-burst request, held until accepted
//   WR_BURSTS  in   4  burst count, sampled on accept
//   ABORT      in   1  synchronous early termination
//   WR_ACK     out  1  request accepted this cycle (combinational)
//   TX_DATA_0  out  8  DQS serial word, bit0 first in time
//   OE_DATA_0  out  4  DQS output enable, one bit per 2 UI, bit0 first
//   DATA_VALID out  1  high in data cycles
//   BUSY       out  1  high whenever not idle
//   ERR        out  1  one-cycle pulse after an accept with an illegal count

module pf_ddr4_dqs_tx_seq #(
  parameter logic [7:0]  DATA_PAT   = 8'b01010101,
  parameter int unsigned MAX_BURSTS = 8
) (
  input  logic       FAB_CLK,
  input  logic       ARST,
  input  logic       WR_REQ,
  input  logic [3:0] WR_BURSTS,
  input  logic       ABORT,
  output logic       WR_ACK,
  output logic [7:0] TX_DATA_0,
  output logic [3:0] OE_DATA_0,
  output logic       DATA_VALID,
  output logic       BUSY,
  output logic       ERR
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PRE  = 2'd1,
    S_DATA = 2'd2,
    S_POST = 2'd3
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] count;
  logic [3:0] count_nxt;
  logic       accept;
  logic       legal;
  logic       err_nxt;
  logic [7:0] tx_nxt;
  logic [3:0] oe_nxt;
  logic       dv_nxt;

`ifdef PF_DDR4_DQS_LONG_PREAMBLE_EN
  // Marks the second of the two preamble cycles.
  logic       pre_second;
  logic       pre_second_nxt;
`endif

  // Accept is offered in IDLE and in the final data cycle; an ABORT in that
  // final cycle withdraws the offer so the pending request stays unacknowledged.
  assign WR_ACK = (state == S_IDLE) ||
                  ((state == S_DATA) && (count == 4'd1) && !ABORT);
  assign accept = WR_REQ && WR_ACK;
  assign legal  = (WR_BURSTS != 4'd0) && (32'(WR_BURSTS) <= MAX_BURSTS);

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    err_nxt   = 1'b0;
`ifdef PF_DDR4_DQS_LONG_PREAMBLE_EN
    pre_second_nxt = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        // ABORT is ignored here; an illegal count only reports an error.
        if (accept) begin
          if (legal) begin
            state_nxt = S_PRE;
            count_nxt = WR_BURSTS;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      S_PRE: begin
        if (ABORT) begin
          state_nxt = S_POST;
          count_nxt = 4'd0;
        end
`ifdef PF_DDR4_DQS_LONG_PREAMBLE_EN
        else if (!pre_second) begin
          pre_second_nxt = 1'b1;
        end
`endif
        else begin
          state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (ABORT) begin
          state_nxt = S_POST;
          count_nxt = 4'd0;
        end else if (count == 4'd1) begin
          if (accept && legal) begin
            // Seamless chaining: reload and keep toggling DQS.
            count_nxt = WR_BURSTS;
          end else begin
            state_nxt = S_POST;
            count_nxt = 4'd0;
            err_nxt   = accept;
          end
        end else begin
          count_nxt = count - 4'd1;
        end
      end
      S_POST: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
        count_nxt = 4'd0;
      end
    endcase
  end

  // Output words are decoded from the next state so they register alongside it.
  always_comb begin
    tx_nxt = 8'h00;
    oe_nxt = 4'h0;
    dv_nxt = 1'b0;
    case (state_nxt)
      S_PRE: begin
`ifdef PF_DDR4_DQS_LONG_PREAMBLE_EN
        oe_nxt = pre_second_nxt ? 4'b1111 : 4'b1100;
`else
        oe_nxt = 4'b1000;
`endif
      end
      S_DATA: begin
        tx_nxt = DATA_PAT;
        oe_nxt = 4'b1111;
        dv_nxt = 1'b1;
      end
      S_POST: begin
        oe_nxt = 4'b0001;
      end
      default: begin
        tx_nxt = 8'h00;
      end
    endcase
  end

  always_ff @(posedge FAB_CLK or posedge ARST) begin
    if (ARST) begin
      state      <= S_IDLE;
      count      <= 4'd0;
      TX_DATA_0  <= 8'h00;
      OE_DATA_0  <= 4'h0;
      DATA_VALID <= 1'b0;
      BUSY       <= 1'b0;
      ERR        <= 1'b0;
`ifdef PF_DDR4_DQS_LONG_PREAMBLE_EN
      pre_second <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      count      <= count_nxt;
      TX_DATA_0  <= tx_nxt;
      OE_DATA_0  <= oe_nxt;
      DATA_VALID <= dv_nxt;
      BUSY       <= (state_nxt != S_IDLE);
      ERR        <= err_nxt;
`ifdef PF_DDR4_DQS_LONG_PREAMBLE_EN
      pre_second <= pre_second_nxt;
`endif
    end
  end

endmodule

// File: doc/pf_ddr4_dqs_tx_seq.md
PF_DDR4_DQS_TX_SEQ -- requirements
Module: pf_ddr4_dqs_tx_seq

Interface
REQ-001 SHALL have parameter DATA_PAT, default 8'b01010101: DQS toggle word for each data cycle (bit0 = first UI in time).
REQ-002 SHALL have parameter MAX_BURSTS, default 8: largest legal WR_BURSTS value (one BL8 burst per FAB_CLK cycle).
REQ-003 SHALL have port FAB_CLK  in  1  the only clock; 4:1 gearing, 8 UI per cycle.
REQ-004 SHALL have port ARST  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port WR_REQ  in  1  write-burst request; held until accepted.
REQ-006 SHALL have port WR_BURSTS  in  4  burst count for the request, sampled on accept.
REQ-007 SHALL have port ABORT  in  1  synchronous early termination request.
REQ-008 SHALL have port WR_ACK  out  1  request accepted this cycle (WR_REQ & WR_ACK = accept).
REQ-009 SHALL have port TX_DATA_0  out  8  DQS serial word to the DQS IOD lane.
REQ-010 SHALL have port OE_DATA_0  out  4  DQS output-enable word, one bit per 2 UI, bit0 first.
REQ-011 SHALL have port DATA_VALID  out  1  high during data cycles; aligns the DQ lanes.
REQ-012 SHALL have port BUSY  out  1  high in any state other than IDLE.
REQ-013 SHALL have port ERR  out  1  one-cycle pulse on an illegal WR_BURSTS value.

Function
REQ-014 SHALL implement states IDLE, PRE, DATA and POST; all outputs except WR_ACK SHALL be registered.
REQ-015 WR_ACK SHALL be combinational: 1 in IDLE, 1 in DATA when remaining count = 1 and ABORT = 0, else 0.
REQ-016 On accept from IDLE with 1 <= WR_BURSTS <= MAX_BURSTS: next state PRE, count loaded with WR_BURSTS.
REQ-017 PRE output: TX_DATA_0 = 8'h00, OE_DATA_0 = 4'b1000, DATA_VALID = 0; next state DATA after exactly 1 cycle.
REQ-018 DATA output: TX_DATA_0 = DATA_PAT, OE_DATA_0 = 4'b1111, DATA_VALID = 1; count decrements by 1 each cycle.
REQ-019 In DATA with count = 1 and no accept: next state POST. POST output: TX_DATA_0 = 8'h00, OE_DATA_0 = 4'b0001, DATA_VALID = 0; next state IDLE.
REQ-020 Seamless: an accept in the last DATA cycle with a legal count SHALL reload the count and stay in DATA, with no POST and no PRE cycle.
REQ-021 Accept with WR_BURSTS = 0 or > MAX_BURSTS SHALL pulse ERR on the next cycle and start no burst.
REQ-021a From IDLE the state SHALL stay IDLE; in the last DATA cycle it SHALL proceed to POST.
REQ-022 ABORT in PRE or DATA SHALL force POST on the next cycle. ABORT SHALL have priority over a simultaneous accept; that request is not acknowledged.
REQ-022a ABORT in IDLE or POST SHALL be ignored.
REQ-023 IDLE output: TX_DATA_0 = 8'h00, OE_DATA_0 = 4'h0, DATA_VALID = 0. Latency from accept to the first DATA cycle SHALL be 2 cycles.
REQ-024 The count SHALL be 4 bits, SHALL never underflow, and SHALL wrap only by reload.

Reset
REQ-025 ARST SHALL immediately force IDLE, count = 0, and TX_DATA_0, OE_DATA_0, DATA_VALID, BUSY and ERR all to 0, including mid-burst.
REQ-026 After ARST deasserts, the first accept SHALL be possible on the first FAB_CLK edge.

Configuration
REQ-027 Macro PF_DDR4_DQS_LONG_PREAMBLE_EN defined: PRE SHALL last 2 cycles; the first cycle drives OE_DATA_0 = 4'b1100, the second drives 4'b1111; TX_DATA_0 = 8'h00 in both. Accept-to-DATA latency becomes 3 cycles.
REQ-028 Macro not defined: single-cycle PRE as in REQ-017.

Verification
REQ-029 Reset release, WR_REQ = 1 with WR_BURSTS = 2 -> WR_ACK = 1; then PRE (OE 4'b1000), two DATA cycles (8'h55, OE 4'hF), POST (OE 4'b0001), then IDLE.
REQ-030 WR_BURSTS = 1, then a second request with WR_BURSTS = 3 held high -> accepted in the last DATA cycle; 4 consecutive DATA cycles with no POST/PRE between them.
REQ-031 WR_BURSTS = 0 and, separately, WR_BURSTS = 9 -> ERR pulses 1 cycle, BUSY stays 0, outputs stay idle.
REQ-032 WR_BURSTS = 8 with ABORT in the 3rd DATA cycle -> POST next cycle, then IDLE; a simultaneous WR_REQ is not acknowledged.
REQ-033 ARST pulsed in the 2nd DATA cycle -> all outputs 0 before the next edge; a new request is accepted on the first edge after release.
REQ-034 With PF_DDR4_DQS_LONG_PREAMBLE_EN defined, WR_BURSTS = 1 -> OE 4'b1100, 4'b1111, then DATA, then POST.
